// File: rtl/perip_pkg.sv
// Shared constants and CTRL register layout for the peripheral timer.
package perip_pkg;

    typedef enum logic [1:0] {
        TMR_CTRL    = 2'd0,
        TMR_COUNT   = 2'd1,
        TMR_COMPARE = 2'd2,
        TMR_STATUS  = 2'd3
    } tmr_reg_e;

    localparam int unsigned CTRL_ENABLE_BIT      = 0;
    localparam int unsigned CTRL_INT_EN_BIT      = 1;
    localparam int unsigned CTRL_AUTO_RELOAD_BIT = 2;
    localparam int unsigned CTRL_PRESCALE_LSB    = 8;
    localparam int unsigned CTRL_PRESCALE_MSB    = 15;

    localparam logic [31:0] TMR_ADDR_BASE = 32'h2000_0000;

    typedef struct packed {
        logic       enable;
        logic       int_en;
        logic       auto_reload;
        logic [7:0] prescale;
    } ctrl_t;

    function automatic logic [31:0] ctrl_pack(input ctrl_t c);
        logic [31:0] w;
        w                                         = '0;
        w[CTRL_ENABLE_BIT]                        = c.enable;
        w[CTRL_INT_EN_BIT]                        = c.int_en;
        w[CTRL_AUTO_RELOAD_BIT]                   = c.auto_reload;
        w[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB]    = c.prescale;
        return w;
    endfunction

    function automatic ctrl_t ctrl_unpack(input logic [31:0] w);
        ctrl_t c;
        c.enable      = w[CTRL_ENABLE_BIT];
        c.int_en      = w[CTRL_INT_EN_BIT];
        c.auto_reload = w[CTRL_AUTO_RELOAD_BIT];
        c.prescale    = w[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
        return c;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock by prescale+1, producing a one-cycle tick while enabled.
module tick_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] prescale,
    input  logic       clear,
    output logic       tick
);

    logic [7:0] pre_cnt;

    assign tick = enable && (pre_cnt == prescale);

    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/perip_timer.sv
// Memory-mapped compare timer: CTRL/COUNT/COMPARE/STATUS registers, prescaled
// counting and a level interrupt on compare match.
module perip_timer
    import perip_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = TMR_ADDR_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_o
);

    ctrl_t       ctrl;
    logic [31:0] count;
    logic [31:0] compare;
    logic        pending;

    logic        sel;
    logic        wr;
    tmr_reg_e    reg_idx;
    logic        tick;
    logic        match;
    logic        unused_addr;

    assign sel         = req_i && (addr_i[31:4] == ADDR_BASE[31:4]);
    assign wr          = sel && wr_en_i;
    assign reg_idx     = tmr_reg_e'(addr_i[3:2]);
    assign match       = tick && (count == compare);
    assign unused_addr = ^addr_i[1:0];

    tick_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (ctrl.enable),
        .prescale (ctrl.prescale),
        .clear    (wr && (reg_idx == TMR_CTRL)),
        .tick     (tick)
    );

    // Bus writes are applied after the tick update so they take priority,
    // except the pending set which must beat a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= '0;
            count   <= '0;
            compare <= '0;
            pending <= 1'b0;
        end else begin
            if (tick) begin
                if (count == compare) begin
                    if (ctrl.auto_reload) begin
                        count <= '0;
                    end else begin
                        ctrl.enable <= 1'b0;
                    end
                end else begin
                    count <= count + 32'd1;
                end
            end

            if (wr) begin
                case (reg_idx)
                    TMR_CTRL:    ctrl    <= ctrl_unpack(data_i);
                    TMR_COUNT:   count   <= data_i;
                    TMR_COMPARE: compare <= data_i;
                    TMR_STATUS:  if (data_i[0]) pending <= 1'b0;
                    default:     ;
                endcase
            end

            if (match) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (sel && !wr_en_i) begin
            case (reg_idx)
                TMR_CTRL:    data_o = ctrl_pack(ctrl);
                TMR_COUNT:   data_o = count;
                TMR_COMPARE: data_o = compare;
                TMR_STATUS:  data_o = {31'd0, pending};
                default:     data_o = '0;
            endcase
        end
    end

    assign int_o = pending && ctrl.int_en;

endmodule
